// File: rtl/popcount_frame_accum.sv
// Frame accumulator for per-byte ones counts: sums clamped counts and beats per frame,
// then holds the result on a registered valid/ready output. Optional out_max via POPACC_MAX_EN.
module popcount_frame_accum #(
    parameter int TOTAL_W = 12,
    parameter int LEN_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_count,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TOTAL_W-1:0] out_total,
    output logic [LEN_W-1:0]   out_bytes,
    output logic               out_ovf,
`ifdef POPACC_MAX_EN
    output logic [3:0]         out_max,
`endif
    output logic               out_err
);

    // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
    // a result transfers where out_valid && out_ready. Neither valid waits on ready.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic [LEN_W-1:0]   bytes_q, bytes_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;
    logic [3:0]         max_q, max_d;

    logic               beat_acc;
    logic [3:0]         clamped;
    logic               beat_err;
    logic [TOTAL_W:0]   sum_ext;
    logic               tot_sat;
    logic               byte_sat;

    assign beat_acc = in_valid && in_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            total_q    <= '0;
            bytes_q    <= '0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
            max_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            total_q    <= total_d;
            bytes_q    <= bytes_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
            max_q      <= max_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACCUM: if (beat_acc) state_d = in_last ? HOLD : ACCUM;
            HOLD:        if (out_ready) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
        // in_ready is registered from the upcoming state, so it is low for exactly the HOLD cycles.
        in_ready_d = (state_d != HOLD);
    end

    always_comb begin
        clamped  = (in_count > 4'd8) ? 4'd8 : in_count;
        beat_err = (in_count > 4'd8);
        sum_ext  = {1'b0, total_q} + (TOTAL_W+1)'(clamped);
        tot_sat  = sum_ext[TOTAL_W];
        byte_sat = (bytes_q == {LEN_W{1'b1}});
        total_d  = total_q;
        bytes_d  = bytes_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        max_d    = max_q;
        if (beat_acc) begin
            if (state_q == IDLE) begin
                // First beat of a frame loads rather than adds, clearing sticky flags.
                total_d = TOTAL_W'(clamped);
                bytes_d = LEN_W'(1);
                ovf_d   = 1'b0;
                err_d   = beat_err;
                max_d   = clamped;
            end else begin
                total_d = tot_sat ? {TOTAL_W{1'b1}} : sum_ext[TOTAL_W-1:0];
                bytes_d = byte_sat ? bytes_q : bytes_q + LEN_W'(1);
                ovf_d   = ovf_q | tot_sat | byte_sat;
                err_d   = err_q | beat_err;
                max_d   = (clamped > max_q) ? clamped : max_q;
            end
        end
    end

    always_comb begin
        out_valid = (state_q == HOLD);
        in_ready  = in_ready_q;
        out_total = total_q;
        out_bytes = bytes_q;
        out_ovf   = ovf_q;
        out_err   = err_q;
`ifdef POPACC_MAX_EN
        out_max   = max_q;
`endif
    end

`ifndef POPACC_MAX_EN
    logic unused_max;
    assign unused_max = ^max_q;
`endif

endmodule
